// File: rtl/seg_scan_decoder_pkg.sv
// Shared definitions for the seven-segment scan decoder: glyph patterns,
// FSM state encodings, default parameter values and small helpers.
package seg_scan_decoder_pkg;

  // Default configuration
  localparam int DEFAULT_SETTLE_CYCLES  = 16;
  localparam int DEFAULT_TIMEOUT_CYCLES = 1048576;

  // Active-low g..a patterns for the sixteen hex glyphs
  localparam logic [6:0] GLYPH_0 = 7'h40;
  localparam logic [6:0] GLYPH_1 = 7'h79;
  localparam logic [6:0] GLYPH_2 = 7'h24;
  localparam logic [6:0] GLYPH_3 = 7'h30;
  localparam logic [6:0] GLYPH_4 = 7'h19;
  localparam logic [6:0] GLYPH_5 = 7'h12;
  localparam logic [6:0] GLYPH_6 = 7'h02;
  localparam logic [6:0] GLYPH_7 = 7'h78;
  localparam logic [6:0] GLYPH_8 = 7'h00;
  localparam logic [6:0] GLYPH_9 = 7'h10;
  localparam logic [6:0] GLYPH_A = 7'h08;
  localparam logic [6:0] GLYPH_B = 7'h03;
  localparam logic [6:0] GLYPH_C = 7'h46;
  localparam logic [6:0] GLYPH_D = 7'h21;
  localparam logic [6:0] GLYPH_E = 7'h06;
  localparam logic [6:0] GLYPH_F = 7'h0E;

  // Scan FSM state encodings
  localparam logic [1:0] ST_WAIT    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_HOLD    = 2'd2;

  // True when exactly one active-low anode is driven
  function automatic logic single_low(input logic [7:0] an);
    logic [7:0] sel;
    sel = ~an;
    return (sel != 8'd0) && ((sel & (sel - 8'd1)) == 8'd0);
  endfunction

  // Index of the low anode bit; only meaningful when single_low() holds
  function automatic logic [2:0] low_index(input logic [7:0] an);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (!an[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg_glyph_decode.sv
// Combinational glyph decoder: 7-bit active-low g..a pattern to hex nibble.
// Any pattern that is not one of the sixteen hex glyphs yields 0 with err set.
module seg_glyph_decode
  import seg_scan_decoder_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       err
);

  // Pattern lookup with an error flag for unknown glyphs
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it unassigned and no latch is inferred.
    nibble = 4'h0;
    err    = 1'b0;
    case (seg)
      GLYPH_0: nibble = 4'h0;
      GLYPH_1: nibble = 4'h1;
      GLYPH_2: nibble = 4'h2;
      GLYPH_3: nibble = 4'h3;
      GLYPH_4: nibble = 4'h4;
      GLYPH_5: nibble = 4'h5;
      GLYPH_6: nibble = 4'h6;
      GLYPH_7: nibble = 4'h7;
      GLYPH_8: nibble = 4'h8;
      GLYPH_9: nibble = 4'h9;
      GLYPH_A: nibble = 4'hA;
      GLYPH_B: nibble = 4'hB;
      GLYPH_C: nibble = 4'hC;
      GLYPH_D: nibble = 4'hD;
      GLYPH_E: nibble = 4'hE;
      GLYPH_F: nibble = 4'hF;
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Seven-segment scan decoder: watches a multiplexed 8-digit display bus,
// captures each digit once its anode/cathode pattern has been stable for
// SETTLE_CYCLES, and publishes a decoded frame once all eight digits are seen.
// Optional feature: define SEG_TIMEOUT_EN to enable the frame timeout counter;
// otherwise timeout is tied low.
module seg_scan_decoder
  import seg_scan_decoder_pkg::*;
#(
  parameter int SETTLE_CYCLES  = DEFAULT_SETTLE_CYCLES,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        CLK100MHZ,
  input  logic        reset_btn,
  input  logic [7:0]  Anodes,
  input  logic [7:0]  Cathodes,
  input  logic        frame_ack,
  output logic [31:0] digit_val,
  output logic [7:0]  dp_val,
  output logic [7:0]  decode_err,
  output logic        frame_valid,
  output logic        overrun,
  output logic        timeout
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  logic [7:0]       an_q, an_prev;
  logic [7:0]       cat_q, cat_prev;
  logic             change;
  logic [CNT_W-1:0] stable_cnt;
  logic [1:0]       state;
  logic             capture;
  logic [2:0]       cap_idx;
  logic [7:0][7:0]  shadow;
  logic [7:0]       seen;
  logic             complete;
  logic [7:0][3:0]  dec_nib;
  logic [7:0]       dec_err;
  logic [7:0]       dec_dp;

  // A change is judged purely on the registered copy of the bus
  assign change   = (an_q != an_prev) || (cat_q != cat_prev);
  assign capture  = (state == ST_CAPTURE) && !change && single_low(an_q);
  assign cap_idx  = low_index(an_q);
  assign complete = (seen == 8'hFF);

  // Register the bus once, keep the previous copy, run the stability counter
  always_ff @(posedge CLK100MHZ or posedge reset_btn) begin
    if (reset_btn) begin
      an_q       <= 8'hFF;
      an_prev    <= 8'hFF;
      cat_q      <= 8'hFF;
      cat_prev   <= 8'hFF;
      stable_cnt <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so an_prev takes the old an_q, not the new one.
      an_q     <= Anodes;
      an_prev  <= an_q;
      cat_q    <= Cathodes;
      cat_prev <= cat_q;
      if (change)
        stable_cnt <= '0;
      else if (stable_cnt != CNT_SAT)
        stable_cnt <= stable_cnt + 1'b1;
    end
  end

  // Scan FSM: settle, capture once, then hold until the bus moves on
  always_ff @(posedge CLK100MHZ or posedge reset_btn) begin
    if (reset_btn) begin
      state <= ST_WAIT;
    end else begin
      case (state)
        ST_WAIT:
          if (stable_cnt == CNT_LAST && !change && single_low(an_q))
            state <= ST_CAPTURE;
        ST_CAPTURE:
          state <= ST_HOLD;
        ST_HOLD:
          if (change) state <= ST_WAIT;
        default:
          state <= ST_WAIT;
      endcase
    end
  end

  // Shadow slots and seen mask; a full mask is consumed on the following cycle
  always_ff @(posedge CLK100MHZ or posedge reset_btn) begin
    if (reset_btn) begin
      // NOTE: the shadow store is small and must read as cleared after reset, so it is reset like any other register.
      shadow <= '0;
      seen   <= '0;
    end else begin
      if (complete) begin
        seen <= '0;
      end else if (capture) begin
        shadow[cap_idx] <= cat_q;
        seen[cap_idx]   <= 1'b1;
      end
    end
  end

  // One decoder per shadow slot
  for (genvar g = 0; g < 8; g++) begin : g_dec
    seg_glyph_decode u_dec (
      .seg    (shadow[g][6:0]),
      .nibble (dec_nib[g]),
      .err    (dec_err[g])
    );
    assign dec_dp[g] = ~shadow[g][7];
  end

  // Publish a completed frame and manage the valid/ack/overrun handshake
  always_ff @(posedge CLK100MHZ or posedge reset_btn) begin
    if (reset_btn) begin
      digit_val   <= '0;
      dp_val      <= '0;
      decode_err  <= '0;
      frame_valid <= 1'b0;
      overrun     <= 1'b0;
    end else if (complete) begin
      digit_val   <= dec_nib;
      dp_val      <= dec_dp;
      decode_err  <= dec_err;
      frame_valid <= 1'b1;
      if (frame_valid && !frame_ack) overrun <= 1'b1;
    end else if (frame_ack) begin
      frame_valid <= 1'b0;
    end
  end

`ifdef SEG_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_cnt;

  // Count cycles since reset or the last completed frame; flag is sticky
  always_ff @(posedge CLK100MHZ or posedge reset_btn) begin
    if (reset_btn) begin
      to_cnt  <= '0;
      timeout <= 1'b0;
    end else if (complete) begin
      to_cnt <= '0;
    end else if (to_cnt == TO_LAST) begin
      timeout <= 1'b1;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  // No timeout hardware; the comparison is a constant zero that keeps the
  // parameter referenced for builds that do not enable the feature.
  assign timeout = (TIMEOUT_CYCLES < 0);
`endif

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder (SETTLE_CYCLES=16, TIMEOUT_CYCLES=1000).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_seg_scan_decoder;

  logic        CLK100MHZ = 1'b0;
  logic        reset_btn = 1'b1;
  logic [7:0]  Anodes    = 8'hFF;
  logic [7:0]  Cathodes  = 8'hFF;
  logic        frame_ack = 1'b0;
  logic [31:0] digit_val;
  logic [7:0]  dp_val;
  logic [7:0]  decode_err;
  logic        frame_valid;
  logic        overrun;
  logic        timeout;

  int checks = 0;
  int errors = 0;

  // Bench-side glyph table (active-low g..a), index = hex value
  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seg_scan_decoder #(
    .SETTLE_CYCLES  (16),
    .TIMEOUT_CYCLES (1000)
  ) dut (
    .CLK100MHZ   (CLK100MHZ),
    .reset_btn   (reset_btn),
    .Anodes      (Anodes),
    .Cathodes    (Cathodes),
    .frame_ack   (frame_ack),
    .digit_val   (digit_val),
    .dp_val      (dp_val),
    .decode_err  (decode_err),
    .frame_valid (frame_valid),
    .overrun     (overrun),
    .timeout     (timeout)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  // Drive one digit for dwell cycles (called on a falling edge)
  task automatic drive_digit(input int idx, input logic [7:0] cath, input int dwell);
    logic [7:0] one;
    one      = 8'h01;
    Anodes   = ~(one << idx);
    Cathodes = cath;
    repeat (dwell) @(negedge CLK100MHZ);
  endtask

  task automatic go_idle();
    Anodes   = 8'hFF;
    Cathodes = 8'hFF;
    repeat (2) @(negedge CLK100MHZ);
  endtask

  // Scan digits lo..hi with digit n showing hex value vals[4n+:4], DP off
  task automatic scan_range(input logic [31:0] vals, input int lo, input int hi, input int dwell);
    for (int n = lo; n <= hi; n++) drive_digit(n, {1'b1, glyph[vals[4*n +: 4]]}, dwell);
  endtask

  task automatic pulse_ack();
    frame_ack = 1'b1;
    @(negedge CLK100MHZ);
    frame_ack = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge CLK100MHZ);
    checks++; if (digit_val !== 32'h0) begin errors++; $display("FAIL reset_digit_val got %h exp 00000000", digit_val); end
    checks++; if (dp_val !== 8'h00) begin errors++; $display("FAIL reset_dp_val got %h exp 00", dp_val); end
    checks++; if (decode_err !== 8'h00) begin errors++; $display("FAIL reset_decode_err got %h exp 00", decode_err); end
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_frame_valid got %b exp 0", frame_valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b exp 0", overrun); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b exp 0", timeout); end
    reset_btn = 1'b0;
    @(negedge CLK100MHZ);
  endtask

  task automatic test_basic_scan();
    scan_range(32'h76543210, 0, 7, 20);
    go_idle();
    checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL basic_frame_valid got %b exp 1", frame_valid); end
    checks++; if (digit_val !== 32'h76543210) begin errors++; $display("FAIL basic_digit_val got %h exp 76543210", digit_val); end
    checks++; if (decode_err !== 8'h00) begin errors++; $display("FAIL basic_decode_err got %h exp 00", decode_err); end
    checks++; if (dp_val !== 8'h00) begin errors++; $display("FAIL basic_dp_val got %h exp 00", dp_val); end
    pulse_ack();
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL basic_ack_clear got %b exp 0", frame_valid); end
  endtask

  task automatic test_short_dwell();
    scan_range(32'h01234567, 0, 7, 10);
    scan_range(32'h01234567, 0, 7, 10);
    go_idle();
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL short_dwell_frame_valid got %b exp 0", frame_valid); end
    checks++; if (digit_val !== 32'h76543210) begin errors++; $display("FAIL short_dwell_digit_val got %h exp 76543210", digit_val); end
  endtask

  task automatic test_multi_low();
    Anodes   = 8'hFC;
    Cathodes = {1'b1, glyph[1]};
    repeat (40) @(negedge CLK100MHZ);
    // Digits 1..7 only: a spurious capture of digit 0 would complete a frame here
    scan_range(32'hFEDCBA98, 1, 7, 20);
    go_idle();
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL multi_low_partial got %b exp 0", frame_valid); end
    scan_range(32'hFEDCBA98, 0, 0, 20);
    go_idle();
    checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL multi_low_frame_valid got %b exp 1", frame_valid); end
    checks++; if (digit_val !== 32'hFEDCBA98) begin errors++; $display("FAIL multi_low_digit_val got %h exp FEDCBA98", digit_val); end
    pulse_ack();
  endtask

  task automatic test_blank_dp();
    drive_digit(0, 8'h40, 20);          // glyph 0 with DP on
    drive_digit(1, {1'b1, glyph[1]}, 20);
    drive_digit(2, {1'b1, glyph[2]}, 20);
    drive_digit(3, 8'hFF, 20);          // blank, DP off
    scan_range(32'h76540000, 4, 7, 20);
    go_idle();
    checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL blank_frame_valid got %b exp 1", frame_valid); end
    checks++; if (decode_err !== 8'h08) begin errors++; $display("FAIL blank_decode_err got %h exp 08", decode_err); end
    checks++; if (dp_val !== 8'h01) begin errors++; $display("FAIL blank_dp_val got %h exp 01", dp_val); end
    checks++; if (digit_val !== 32'h76540210) begin errors++; $display("FAIL blank_digit_val got %h exp 76540210", digit_val); end
    pulse_ack();
  endtask

  task automatic test_ack_same_cycle();
    scan_range(32'h76543210, 0, 7, 20);
    go_idle();
    scan_range(32'hFEDCBA98, 0, 6, 20);
    // Last digit: capture at the 19th edge after it is driven, frame publishes on the 20th
    drive_digit(7, {1'b1, glyph[4'hF]}, 19);
    frame_ack = 1'b1;
    @(negedge CLK100MHZ);
    frame_ack = 1'b0;
    go_idle();
    checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL ack_same_frame_valid got %b exp 1", frame_valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ack_same_overrun got %b exp 0", overrun); end
    checks++; if (digit_val !== 32'hFEDCBA98) begin errors++; $display("FAIL ack_same_digit_val got %h exp FEDCBA98", digit_val); end
    pulse_ack();
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL ack_same_clear got %b exp 0", frame_valid); end
  endtask

  task automatic test_overrun();
    scan_range(32'h76543210, 0, 7, 20);
    go_idle();
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_first_frame got %b exp 0", overrun); end
    scan_range(32'h89ABCDEF, 0, 7, 20);
    go_idle();
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set got %b exp 1", overrun); end
    checks++; if (digit_val !== 32'h89ABCDEF) begin errors++; $display("FAIL overrun_digit_val got %h exp 89ABCDEF", digit_val); end
    checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL overrun_frame_valid got %b exp 1", frame_valid); end
    pulse_ack();
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL overrun_ack_clear got %b exp 0", frame_valid); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky got %b exp 1", overrun); end
  endtask

  task automatic test_reset_mid_frame();
    scan_range(32'h00011111, 0, 4, 20);
    go_idle();
    reset_btn = 1'b1;
    #1;
    checks++; if (digit_val !== 32'h0) begin errors++; $display("FAIL midreset_digit_val got %h exp 00000000", digit_val); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL midreset_overrun got %b exp 0", overrun); end
    @(negedge CLK100MHZ);
    reset_btn = 1'b0;
    @(negedge CLK100MHZ);
    // Stale seen bits for digits 0..4 would complete a frame after these three
    scan_range(32'h76500000, 5, 7, 20);
    go_idle();
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL midreset_partial got %b exp 0", frame_valid); end
    scan_range(32'h00043210, 0, 4, 20);
    go_idle();
    checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL midreset_frame_valid got %b exp 1", frame_valid); end
    checks++; if (digit_val !== 32'h76543210) begin errors++; $display("FAIL midreset_digit_val2 got %h exp 76543210", digit_val); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL midreset_single_frame got %b exp 0", overrun); end
  endtask

  task automatic test_timeout();
    reset_btn = 1'b1;
    @(negedge CLK100MHZ);
    reset_btn = 1'b0;
`ifdef SEG_TIMEOUT_EN
    repeat (999) @(posedge CLK100MHZ);
    #1;
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL timeout_early got %b exp 0", timeout); end
    @(posedge CLK100MHZ);
    #1;
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL timeout_at_1000 got %b exp 1", timeout); end
    repeat (20) @(negedge CLK100MHZ);
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL timeout_sticky got %b exp 1", timeout); end
`else
    repeat (1100) @(negedge CLK100MHZ);
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL timeout_disabled got %b exp 0", timeout); end
`endif
    @(negedge CLK100MHZ);
  endtask

  initial begin
    test_reset();
    test_basic_scan();
    test_short_dwell();
    test_multi_low();
    test_blank_dp();
    test_ack_same_cycle();
    test_overrun();
    test_reset_mid_frame();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
